// File: rtl/note_tone_gen_if.sv
// Note-to-PCM link: frequency word and frame request in, signed sample and status out.
// Master drives freq_in/sample_req; slave (the tone generator) drives the rest.
interface note_tone_gen_if #(
  parameter int ACC_W    = 32,
  parameter int SAMPLE_W = 16
);
  logic [ACC_W-1:0]           freq_in;
  logic                       sample_req;
  logic signed [SAMPLE_W-1:0] sample_out;
  logic                       sample_valid;
  logic                       active;
  logic                       overrun;

  modport master (
    output freq_in,
    output sample_req,
    input  sample_out,
    input  sample_valid,
    input  active,
    input  overrun
  );

  modport slave (
    input  freq_in,
    input  sample_req,
    output sample_out,
    output sample_valid,
    output active,
    output overrun
  );
endinterface

// File: rtl/note_tone_gen.sv
// Phase-accumulator square wave with attack/sustain/release envelope; 2-cycle request-to-sample
// latency, no backpressure: requests landing on an in-flight sample are dropped and flag sticky overrun.
module note_tone_gen #(
  parameter int ACC_W        = 32,
  parameter int SAMPLE_W     = 16,
  parameter int AMP_MAX      = 8192,
  parameter int ATTACK_STEP  = 64,
  parameter int RELEASE_STEP = 32
) (
  input  logic          clk,
  input  logic          reset,
  note_tone_gen_if.slave tone
);

  localparam int AW = SAMPLE_W - 1;
  localparam int EW = SAMPLE_W + 1;

  localparam logic [EW-1:0] MAX_E = EW'(AMP_MAX);
  localparam logic [EW-1:0] ATK_E = EW'(ATTACK_STEP);
  localparam logic [EW-1:0] REL_E = EW'(RELEASE_STEP);
  localparam logic [AW-1:0] MAX_A = AW'(AMP_MAX);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ATTACK  = 2'd1;
  localparam logic [1:0] S_SUSTAIN = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]                 state;
  logic [1:0]                 state_nxt;
  logic [AW-1:0]              amp;
  logic [AW-1:0]              amp_nxt;
  logic [ACC_W-1:0]           phase;
  logic [ACC_W-1:0]           phase_nxt;
  logic                       stage1;
  logic                       valid_q;
  logic                       active_q;
  logic                       overrun_q;
  logic signed [SAMPLE_W-1:0] sample_q;

  logic                       busy;
  logic                       accept;
  logic                       freq_nz;
  logic [EW-1:0]              amp_e;
  logic [EW-1:0]              amp_sum;
  logic [EW-1:0]              amp_up;
  logic [EW-1:0]              amp_dn;
  logic [SAMPLE_W-1:0]        mag;
  logic [SAMPLE_W-1:0]        mag_neg;

  // Busy for the two cycles after an accepted request (envelope update, then output).
  assign busy    = stage1 | valid_q;
  assign accept  = tone.sample_req & ~busy;
  assign freq_nz = (tone.freq_in != '0);

  // Extended-width envelope arithmetic so step sums never wrap before saturation.
  assign amp_e   = {2'b00, amp};
  assign amp_sum = amp_e + ATK_E;
  assign amp_up  = (amp_sum >= MAX_E) ? MAX_E : amp_sum;
  assign amp_dn  = (amp_e <= REL_E) ? '0 : (amp_e - REL_E);

  assign mag     = {1'b0, amp};
  assign mag_neg = (~mag) + SAMPLE_W'(1);

  always_comb begin
    state_nxt = state;
    amp_nxt   = amp;
    phase_nxt = phase + tone.freq_in;
    case (state)
      S_IDLE: begin
        if (freq_nz) begin
          amp_nxt   = amp_up[AW-1:0];
          state_nxt = (amp_up == MAX_E) ? S_SUSTAIN : S_ATTACK;
          phase_nxt = tone.freq_in;
        end else begin
          amp_nxt   = '0;
          phase_nxt = '0;
        end
      end
      S_ATTACK, S_RELEASE: begin
        if (freq_nz) begin
          amp_nxt   = amp_up[AW-1:0];
          state_nxt = (amp_up == MAX_E) ? S_SUSTAIN : S_ATTACK;
        end else begin
          amp_nxt   = amp_dn[AW-1:0];
          state_nxt = (amp_dn == '0) ? S_IDLE : S_RELEASE;
          if (amp_dn == '0) phase_nxt = '0;
        end
      end
      S_SUSTAIN: begin
        if (freq_nz) begin
          amp_nxt = MAX_A;
        end else begin
          amp_nxt   = amp_dn[AW-1:0];
          state_nxt = (amp_dn == '0) ? S_IDLE : S_RELEASE;
          if (amp_dn == '0) phase_nxt = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        amp_nxt   = '0;
        phase_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      amp       <= '0;
      phase     <= '0;
      stage1    <= 1'b0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      overrun_q <= 1'b0;
      sample_q  <= '0;
    end else begin
      stage1   <= accept;
      valid_q  <= stage1;
      active_q <= (state != S_IDLE);
      if (tone.sample_req && busy) overrun_q <= 1'b1;
      // freq_in is consumed at the request edge, so no separate frequency latch is kept.
      if (accept) begin
        state <= state_nxt;
        amp   <= amp_nxt;
        phase <= phase_nxt;
      end
      if (stage1) sample_q <= phase[ACC_W-1] ? $signed(mag_neg) : $signed(mag);
    end
  end

  assign tone.sample_out   = sample_q;
  assign tone.sample_valid = valid_q;
  assign tone.active       = active_q;
  assign tone.overrun      = overrun_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen: per-cycle comparison against an arithmetic envelope model,
// plus literal expectations at key points of attack, glide, release, retrigger and overrun.
module tb_note_tone_gen;

  typedef struct {
    int                 cyc;
    logic signed [15:0] s;
    bit                 act;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t q[$];
  int   m_amp;
  int   m_st;       // 0 idle, 1 attack, 2 sustain, 3 release
  bit [31:0] m_ph;
  int   la;
  int   ov_cyc;
  bit   exp_act;
  int   last_sample = 0;

  note_tone_gen_if #(.ACC_W(32), .SAMPLE_W(16)) tone ();

  note_tone_gen #(
    .ACC_W(32), .SAMPLE_W(16), .AMP_MAX(8192), .ATTACK_STEP(64), .RELEASE_STEP(32)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .tone  (tone)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_amp   = 0;
    m_st    = 0;
    m_ph    = '0;
    la      = -10;
    ov_cyc  = -1;
    exp_act = 1'b0;
  endtask

  // Envelope rules applied to one request arriving in the current cycle.
  task automatic model_req(input logic [31:0] f);
    exp_t e;
    if (cyc - la <= 2) begin
      if (ov_cyc < 0) ov_cyc = cyc + 1;
      return;
    end
    la = cyc;
    if (f != 0) begin
      if (m_st == 0) m_ph = '0;
      m_ph = m_ph + f;
      if (m_st != 2) begin
        m_amp = (m_amp + 64 > 8192) ? 8192 : m_amp + 64;
        m_st  = (m_amp == 8192) ? 2 : 1;
      end
    end else if (m_st != 0) begin
      m_amp = (m_amp < 32) ? 0 : m_amp - 32;
      m_st  = (m_amp == 0) ? 0 : 3;
      if (m_st == 0) m_ph = '0;
    end
    e.cyc = cyc + 2;
    e.s   = m_ph[31] ? 16'(-m_amp) : 16'(m_amp);
    e.act = (m_st != 0);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    bit exp_v;
    exp_v = (q.size() > 0) && (q[0].cyc == cyc);
    chk("valid", int'(tone.sample_valid), int'(exp_v));
    if (exp_v) begin
      chk("sample", int'(tone.sample_out), int'(q[0].s));
      exp_act = q[0].act;
      q.pop_front();
    end
    if (tone.sample_valid) last_sample = int'(tone.sample_out);
    chk("active", int'(tone.active), int'(exp_act));
    chk("overrun", int'(tone.overrun), int'(ov_cyc >= 0 && cyc >= ov_cyc));
    if (!rst) chk("rst_sample", int'(tone.sample_out), 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] f, input int gap);
    tone.freq_in    = f;
    tone.sample_req = 1'b1;
    model_req(f);
    tick();
    tone.sample_req = 1'b0;
    tone.freq_in    = $urandom;
    repeat (gap - 1) tick();
  endtask

  initial begin
    rst             = 1'b1;
    tone.freq_in    = '0;
    tone.sample_req = 1'b0;
    model_reset();
    #2 rst = 1'b0;

    // Requests while held in reset must have no effect.
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      tone.freq_in    = $urandom;
      tone.sample_req = 1'b1;
      tick();
      tone.sample_req = 1'b0;
      tick();
    end
    chk("rst_out", int'(tone.sample_out), 0);
    chk("rst_valid", int'(tone.sample_valid), 0);
    chk("rst_active", int'(tone.active), 0);
    chk("rst_overrun", int'(tone.overrun), 0);
    rst = 1'b1;
    repeat (2) tick();

    // Attack to sustain, one full phase period at 0x0100_0000.
    for (int k = 1; k <= 256; k++) begin
      send(32'h0100_0000, 3);
      if (k == 1) begin
        chk("atk_first", last_sample, 64);
        chk("atk_active", int'(tone.active), 1);
      end
      if (k == 127) chk("atk127", last_sample, 8128);
      if (k == 128) chk("atk128", last_sample, -8192);
      if (k == 256) chk("sus256", last_sample, 8192);
    end

    // Glide to double frequency in sustain.
    for (int j = 1; j <= 64; j++) begin
      send(32'h0200_0000, 3);
      if (j == 63) chk("glide63", last_sample, 8192);
      if (j == 64) chk("glide64", last_sample, -8192);
    end

    // Full release down to idle.
    for (int j = 1; j <= 256; j++) begin
      send(32'h0, 3);
      if (j == 1) chk("rel_first", last_sample, -8160);
      if (j == 256) begin
        chk("rel_end", last_sample, 0);
        chk("rel_inactive", int'(tone.active), 0);
      end
    end
    for (int j = 0; j < 3; j++) send(32'h0, 3);
    chk("idle_zero", last_sample, 0);

    // Retrigger from mid-release at amp 4000.
    for (int j = 0; j < 128; j++) send(32'h0100_0000, 3);
    for (int j = 0; j < 131; j++) send(32'h0, 3);
    chk("rel4000", last_sample, -4000);
    send(32'h0100_0000, 3);
    chk("retrig", last_sample, -4064);
    for (int j = 0; j < 4; j++) send(32'h0100_0000, 3);

    // Overrun: requests at N+1 and N+2 are dropped.
    chk("ov_clear", int'(tone.overrun), 0);
    send(32'h0100_0000, 1);
    send(32'h0300_0000, 3);
    chk("ov_set", int'(tone.overrun), 1);
    send(32'h0100_0000, 2);
    send(32'h0500_0000, 3);
    send(32'h0100_0000, 3);
    chk("ov_sticky", int'(tone.overrun), 1);

    // Reset with a sample in flight.
    send(32'h0100_0000, 1);
    rst = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("mid_rst_overrun", int'(tone.overrun), 0);
    chk("mid_rst_active", int'(tone.active), 0);
    rst = 1'b1;
    tick();
    send(32'h0100_0000, 3);
    chk("post_rst_first", last_sample, 64);

    repeat (4) tick();
    chk("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
